loc_pack_buffer: RTL
====================

Name: loc_pack_buffer

Overview:
Parametrised double-banked (ping-pong) location buffer. Packs a stream of DATA_W-bit location words into PACK-word entries, DEPTH entries per bank. A writer fills one bank while a reader drains the other, word by word, in arrival order. Has valid/ready handshakes on both sides and early bank close via in_last. Sits between the location fetch stream and the downstream location consumer.

Parameters:
DATA_W, 32, width of one location word
PACK, 2, words packed per storage entry (entry width DATA_W*PACK)
DEPTH, 512, entries per bank; bank capacity CAP = DEPTH*PACK words

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
in_valid  in  1  input word valid
in_ready  out  1  buffer accepts a word this cycle
in_data  in  DATA_W  input location word
in_last  in  1  qualified by in_valid: accepted word closes current write bank
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts output word
out_data  out  DATA_W  output location word
out_last  out  1  out_data is final word of the draining bank
wr_count  out  $clog2(CAP+1)  words stored in current write bank

Behaviour:
- Reset (rst=0, async): both banks EMPTY, wr_bank=0, rd_bank=0, all word/entry pointers 0, stored lengths 0. in_ready=0 while rst=0, then 1 from the first clock edge after release. out_valid=0, out_last=0, wr_count=0. Memory contents are not reset.
- Per-bank state: EMPTY -> FILLING (first word accepted) -> FULL (closed) -> EMPTY (last word read). Stored state is registered.
- Write accept = in_valid & in_ready. in_ready = 1 iff bank[wr_bank] is EMPTY or FILLING.
- On accept: store in_data at entry wr_entry, slice wr_word (bits wr_word*DATA_W +: DATA_W). Then wr_word increments; it wraps to 0 after PACK-1 and wr_entry increments. wr_count increments.
- Close when the accepted word is word CAP-1, or in_last=1. Both together cause one close. On close: latch length = wr_count+1 for that bank, set FULL, toggle wr_bank, and reset wr_word, wr_entry and wr_count to 0. A partial entry's unused slices are never read.
- Read side: out_valid = bank[rd_bank] FULL. out_data = slice rd_word of entry rd_entry of bank rd_bank, driven combinationally from registered pointers. out_last = out_valid & (read index == length-1).
- On out_valid & out_ready: advance rd_word/rd_entry in the same order as the write side. If out_last: set bank EMPTY, toggle rd_bank, reset read pointers.
- Latency: a closed bank raises out_valid the cycle after the close edge. A released bank raises in_ready the cycle after the release edge, so there is no same-cycle bypass.
- The writer and reader act on different banks, so simultaneous accept, close and release in one cycle are all legal and independent.
- Both banks FULL: in_ready=0. in_data is ignored while in_valid&!in_ready.
- out_data and out_last are don't-care while out_valid=0. Held stable while out_valid & !out_ready.
- Reset asserted mid-operation discards all buffered data. No partial output after release.

Test Plan:
- Bench parameters DATA_W=32, PACK=2, DEPTH=4 (CAP=8). Reset, then stream 0x100..0x107 with out_ready=0 -> bank0 closes on 0x107. The next cycle out_valid=1, out_data=0x100, wr_count=0, in_ready=1 (bank1).
- Stream 16 words 0x200..0x20F with out_ready=0 -> both banks FULL and in_ready=0 after the 16th accept. Word 17 is held off. Raise out_ready -> outputs 0x200..0x207 with out_last on 0x207. in_ready=1 the cycle after that release.
- Send 3 words 0xA0,0xA1,0xA2 with in_last on 0xA2 -> out emits exactly 0xA0,0xA1,0xA2, out_last on 0xA2. The partial entry's slice 1 is never emitted.
- in_last on the 8th word of a bank -> a single close with length 8. The next bank starts empty with wr_count=0.
- Continuous in_valid=1 and out_ready=1 with 40 words -> output sequence equals input order, with no loss or duplication.
- Assert rst=0 mid-drain, between clock edges -> out_valid and in_ready drop immediately. After release, out_valid=0 until a new bank closes.

Source files
------------

// File: rtl/loc_pack_buffer.sv
// Ping-pong location buffer: packs DATA_W-bit words into PACK-word entries,
// one bank filling while the other drains in arrival order.
module loc_pack_buffer #(
  parameter int DATA_W = 32,
  parameter int PACK   = 2,
  parameter int DEPTH  = 512
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_last,
  output logic [$clog2(DEPTH*PACK+1)-1:0]     wr_count
);

  localparam int CAP = DEPTH * PACK;
  localparam int CW  = $clog2(CAP + 1);
  localparam int EW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW  = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;

  bank_state_e             state_q [2];
  logic [CW-1:0]           len_q   [2];
  logic                    wr_bank_q, rd_bank_q, ready_en_q;
  logic [WW-1:0]           wr_word_q, wr_word_d, rd_word_q, rd_word_d;
  logic [EW-1:0]           wr_entry_q, wr_entry_d, rd_entry_q, rd_entry_d;
  logic [CW-1:0]           wr_count_q, rd_count_q;
  logic [PACK*DATA_W-1:0]  mem [2][DEPTH];
  logic [PACK*DATA_W-1:0]  rd_line;
  logic                    wr_accept, wr_close, rd_fire;

  // ready_en_q keeps in_ready low until the first edge after reset release
  assign in_ready  = ready_en_q && (state_q[wr_bank_q] != FULL);
  assign wr_accept = in_valid && in_ready;
  assign wr_close  = wr_accept && (in_last || (wr_count_q == CW'(CAP - 1)));
  assign out_valid = (state_q[rd_bank_q] == FULL);
  assign out_last  = out_valid && (rd_count_q == len_q[rd_bank_q] - CW'(1));
  assign rd_fire   = out_valid && out_ready;
  assign wr_count  = wr_count_q;

  always_comb begin
    wr_word_d  = wr_word_q + WW'(1);
    wr_entry_d = wr_entry_q;
    if (wr_word_q == WW'(PACK - 1)) begin
      wr_word_d  = '0;
      wr_entry_d = wr_entry_q + EW'(1);
    end
    rd_word_d  = rd_word_q + WW'(1);
    rd_entry_d = rd_entry_q;
    if (rd_word_q == WW'(PACK - 1)) begin
      rd_word_d  = '0;
      rd_entry_d = rd_entry_q + EW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < PACK; i++) begin
        if (wr_word_q == WW'(i))
          mem[wr_bank_q][wr_entry_q][i*DATA_W +: DATA_W] <= in_data;
      end
    end
  end

  assign rd_line = mem[rd_bank_q][rd_entry_q];

  always_comb begin
    out_data = '0;
    for (int i = 0; i < PACK; i++) begin
      if (rd_word_q == WW'(i))
        out_data = rd_line[i*DATA_W +: DATA_W];
    end
  end

  // Writer and reader always own different banks, so both may update state_q together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= EMPTY;
        len_q[i]   <= '0;
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      ready_en_q <= 1'b0;
      wr_word_q  <= '0;
      wr_entry_q <= '0;
      wr_count_q <= '0;
      rd_word_q  <= '0;
      rd_entry_q <= '0;
      rd_count_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (wr_accept) begin
        if (wr_close) begin
          state_q[wr_bank_q] <= FULL;
          len_q[wr_bank_q]   <= wr_count_q + CW'(1);
          wr_bank_q          <= ~wr_bank_q;
          wr_word_q          <= '0;
          wr_entry_q         <= '0;
          wr_count_q         <= '0;
        end else begin
          state_q[wr_bank_q] <= FILLING;
          wr_word_q          <= wr_word_d;
          wr_entry_q         <= wr_entry_d;
          wr_count_q         <= wr_count_q + CW'(1);
        end
      end
      if (rd_fire) begin
        if (out_last) begin
          state_q[rd_bank_q] <= EMPTY;
          rd_bank_q          <= ~rd_bank_q;
          rd_word_q          <= '0;
          rd_entry_q         <= '0;
          rd_count_q         <= '0;
        end else begin
          rd_word_q          <= rd_word_d;
          rd_entry_q         <= rd_entry_d;
          rd_count_q         <= rd_count_q + CW'(1);
        end
      end
    end
  end

endmodule
